signal_conflict_monitor: RTL and testbench
==========================================

SIGNAL_CONFLICT_MONITOR -- requirements
Module: signal_conflict_monitor

Interface
REQ-001 SHALL have parameter Y2RDELAY, default 3, minimum consecutive YELLOW samples per road before RED.
REQ-002 SHALL have parameter R2GDELAY, default 2, minimum consecutive all-RED samples before either road goes GREEN.
REQ-003 SHALL have parameter MAX_WAIT, default 20, maximum consecutive cycles with CAR_ON_CNTRY_RD high and CNTRY_SIG not GREEN.
REQ-004 SHALL have one clock and an asynchronous active-low reset.
REQ-005 CLOCK  input  1  clock; all state updates on the rising edge.
REQ-006 CLEAR_N  input  1  asynchronous active-low reset.
REQ-007 MAIN_SIG  input  2  main-road lamp state: 0=RED, 1=YELLOW, 2=GREEN, 3=illegal.
REQ-008 CNTRY_SIG  input  2  country-road lamp state, same encoding.
REQ-009 CAR_ON_CNTRY_RD  input  1  country-road car sensor.
REQ-010 FAULT_ACK  input  1  operator acknowledge; clears a latched fault.
REQ-011 FAULT  output  1  sticky fault flag.
REQ-012 FAULT_CODE  output  3  first captured fault: 0 none, 1 ILLEGAL, 2 CONFLICT, 3 SEQ, 4 SHORT_YELLOW, 5 SHORT_CLEAR, 6 STARVE.
REQ-013 FAULT_TIME  output  16  value of the cycle counter at the capturing edge.
REQ-014 FORCE_RED  output  1  request to cabinet to force all-red; equals FAULT.

Function
REQ-015 SHALL sample MAIN_SIG, CNTRY_SIG and CAR_ON_CNTRY_RD on every rising edge and hold the previous sample per road.
REQ-016 SHALL keep a 16-bit free-running cycle counter that starts at 0 after reset, increments every edge and wraps from 0xFFFF to 0.
REQ-017 ILLEGAL SHALL be detected when either sampled road value is 3.
REQ-018 CONFLICT SHALL be detected when both sampled roads are non-RED.
REQ-019 SEQ SHALL be detected on a per-road transition GREEN->RED, YELLOW->GREEN or RED->YELLOW; legal transitions are GREEN->YELLOW, YELLOW->RED, RED->GREEN and hold.
REQ-020 SHALL count consecutive YELLOW samples per road in a counter saturating at Y2RDELAY; SHORT_YELLOW is detected on YELLOW->RED when the count is below Y2RDELAY.
REQ-021 SHALL count consecutive samples with both roads RED in a counter saturating at R2GDELAY; SHORT_CLEAR is detected on either road's RED->GREEN when the count taken before that sample is below R2GDELAY.
REQ-022 SHALL count consecutive cycles with CAR_ON_CNTRY_RD high and CNTRY_SIG not GREEN, saturating at MAX_WAIT; STARVE is detected when the count reaches MAX_WAIT.
REQ-023 The starvation counter SHALL reset to 0 when CAR_ON_CNTRY_RD is low or CNTRY_SIG is GREEN.
REQ-024 The first sample after reset SHALL only prime the history registers; SEQ, SHORT_YELLOW and SHORT_CLEAR are not evaluated on that edge.
REQ-025 ILLEGAL and CONFLICT SHALL be checked on every sample, including the first one.
REQ-026 When several faults occur on one edge, priority SHALL be ILLEGAL > CONFLICT > SEQ > SHORT_YELLOW > SHORT_CLEAR > STARVE.
REQ-027 With FAULT low, a detected fault SHALL, at that same edge, set FAULT, load FAULT_CODE and load FAULT_TIME with the current counter value.
REQ-028 With FAULT high, later faults SHALL NOT change FAULT_CODE or FAULT_TIME.
REQ-029 FAULT_ACK high with FAULT high and no fault detected that edge SHALL clear FAULT, set FAULT_CODE=0 and leave FAULT_TIME unchanged.
REQ-030 A fault detected on the same edge as FAULT_ACK SHALL win: FAULT stays 1 and the new code and time are loaded.
REQ-031 Lamp history and all counters SHALL keep tracking while FAULT is high.

Reset
REQ-032 While CLEAR_N is low, FAULT, FORCE_RED, FAULT_CODE, FAULT_TIME, the cycle counter, all run counters and the primed flag SHALL be 0, independent of CLOCK.
REQ-033 Reset asserted mid-operation SHALL discard any latched fault; the first edge after release is an unprimed sample.

Verification
REQ-034 Legal cycle: main G x10 -> Y x3 -> both R x2 -> country G, ack idle -> FAULT stays 0, FAULT_CODE=0.
REQ-035 Main G, country G on the same sample at cycle 40 -> FAULT=1, FAULT_CODE=2, FAULT_TIME=40, FORCE_RED=1 after that edge.
REQ-036 Main Y for 2 samples then R -> FAULT_CODE=4; a later conflict does not change the code; FAULT_ACK on a clean edge -> FAULT=0, FAULT_CODE=0.
REQ-037 Main G->R directly, with MAIN_SIG=3 on a later edge -> FAULT_CODE=3 on the G->R edge; separately, a value of 3 with no prior fault -> FAULT_CODE=1.
REQ-038 CAR_ON_CNTRY_RD high for 20 cycles with country RED -> FAULT_CODE=6 on the 20th edge; a drop of the sensor at cycle 19 -> no fault.
REQ-039 Latch a fault, then pulse CLEAR_N low asynchronously -> all outputs 0 immediately; the first post-reset sample with main G and no prior clearance raises no SHORT_CLEAR.

Source files
------------

// File: rtl/signal_conflict_monitor.sv
// Traffic-lamp supervisor: watches both road lamps and the country-road sensor,
// latches the first safety fault with its cycle stamp and requests all-red.
module signal_conflict_monitor #(
   parameter int Y2RDELAY = 3,
   parameter int R2GDELAY = 2,
   parameter int MAX_WAIT = 20
) (
   input  logic        CLOCK,
   input  logic        CLEAR_N,
   input  logic [1:0]  MAIN_SIG,
   input  logic [1:0]  CNTRY_SIG,
   input  logic        CAR_ON_CNTRY_RD,
   input  logic        FAULT_ACK,
   output logic        FAULT,
   output logic [2:0]  FAULT_CODE,
   output logic [15:0] FAULT_TIME,
   output logic        FORCE_RED
);

   localparam int YW = $clog2(Y2RDELAY + 1);
   localparam int CW = $clog2(R2GDELAY + 1);
   localparam int SW = $clog2(MAX_WAIT + 1);
   localparam logic [YW-1:0] Y_SAT = YW'(Y2RDELAY);
   localparam logic [CW-1:0] C_SAT = CW'(R2GDELAY);
   localparam logic [SW-1:0] S_SAT = SW'(MAX_WAIT);

   localparam logic [1:0] LAMP_RED    = 2'd0;
   localparam logic [1:0] LAMP_YELLOW = 2'd1;
   localparam logic [1:0] LAMP_GREEN  = 2'd2;
   localparam logic [1:0] LAMP_BAD    = 2'd3;

   localparam logic [2:0] CODE_NONE    = 3'd0;
   localparam logic [2:0] CODE_ILLEGAL = 3'd1;
   localparam logic [2:0] CODE_CONFL   = 3'd2;
   localparam logic [2:0] CODE_SEQ     = 3'd3;
   localparam logic [2:0] CODE_SHORT_Y = 3'd4;
   localparam logic [2:0] CODE_SHORT_C = 3'd5;
   localparam logic [2:0] CODE_STARVE  = 3'd6;

   function automatic logic bad_step(input logic [1:0] prev, input logic [1:0] cur);
      return ((prev == LAMP_GREEN)  && (cur == LAMP_RED))    ||
             ((prev == LAMP_YELLOW) && (cur == LAMP_GREEN))  ||
             ((prev == LAMP_RED)    && (cur == LAMP_YELLOW));
   endfunction

   logic [15:0]   cyc_r;
   logic [1:0]    main_prev_r, cntry_prev_r;
   logic          primed_r;
   logic [YW-1:0] main_yel_r, cntry_yel_r, main_yel_s, cntry_yel_s;
   logic [CW-1:0] clr_r, clr_s;
   logic [SW-1:0] starve_r, starve_s;
   logic          fault_r, fault_s;
   logic [2:0]    code_r, code_s, det_s;
   logic [15:0]   time_r, time_s;
   logic          ill_s, conf_s, seq_s, short_y_s, short_c_s, starve_hit_s;

   // Run counters: each saturates at its threshold and restarts when its condition breaks.
   always_comb begin
      main_yel_s  = {YW{1'b0}};
      cntry_yel_s = {YW{1'b0}};
      clr_s       = {CW{1'b0}};
      starve_s    = {SW{1'b0}};
      if (MAIN_SIG == LAMP_YELLOW) begin
         main_yel_s = (main_yel_r == Y_SAT) ? main_yel_r : main_yel_r + YW'(1);
      end else begin
         main_yel_s = {YW{1'b0}};
      end
      if (CNTRY_SIG == LAMP_YELLOW) begin
         cntry_yel_s = (cntry_yel_r == Y_SAT) ? cntry_yel_r : cntry_yel_r + YW'(1);
      end else begin
         cntry_yel_s = {YW{1'b0}};
      end
      if ((MAIN_SIG == LAMP_RED) && (CNTRY_SIG == LAMP_RED)) begin
         clr_s = (clr_r == C_SAT) ? clr_r : clr_r + CW'(1);
      end else begin
         clr_s = {CW{1'b0}};
      end
      if (CAR_ON_CNTRY_RD && (CNTRY_SIG != LAMP_GREEN)) begin
         starve_s = (starve_r == S_SAT) ? starve_r : starve_r + SW'(1);
      end else begin
         starve_s = {SW{1'b0}};
      end
   end

   // Fault detection; history-based checks need a primed previous sample.
   always_comb begin
      ill_s        = (MAIN_SIG == LAMP_BAD) || (CNTRY_SIG == LAMP_BAD);
      conf_s       = (MAIN_SIG != LAMP_RED) && (CNTRY_SIG != LAMP_RED);
      seq_s        = primed_r && (bad_step(main_prev_r, MAIN_SIG) || bad_step(cntry_prev_r, CNTRY_SIG));
      short_y_s    = primed_r &&
                     (((main_prev_r == LAMP_YELLOW) && (MAIN_SIG == LAMP_RED) && (main_yel_r < Y_SAT)) ||
                      ((cntry_prev_r == LAMP_YELLOW) && (CNTRY_SIG == LAMP_RED) && (cntry_yel_r < Y_SAT)));
      short_c_s    = primed_r && (clr_r < C_SAT) &&
                     (((main_prev_r == LAMP_RED) && (MAIN_SIG == LAMP_GREEN)) ||
                      ((cntry_prev_r == LAMP_RED) && (CNTRY_SIG == LAMP_GREEN)));
      starve_hit_s = (starve_s == S_SAT);
      if (ill_s) begin
         det_s = CODE_ILLEGAL;
      end else if (conf_s) begin
         det_s = CODE_CONFL;
      end else if (seq_s) begin
         det_s = CODE_SEQ;
      end else if (short_y_s) begin
         det_s = CODE_SHORT_Y;
      end else if (short_c_s) begin
         det_s = CODE_SHORT_C;
      end else if (starve_hit_s) begin
         det_s = CODE_STARVE;
      end else begin
         det_s = CODE_NONE;
      end
   end

   // Fault latch: a new fault loads when idle or when it coincides with an acknowledge.
   always_comb begin
      fault_s = fault_r;
      code_s  = code_r;
      time_s  = time_r;
      if ((det_s != CODE_NONE) && (!fault_r || FAULT_ACK)) begin
         fault_s = 1'b1;
         code_s  = det_s;
         time_s  = cyc_r;
      end else if ((det_s == CODE_NONE) && fault_r && FAULT_ACK) begin
         fault_s = 1'b0;
         code_s  = CODE_NONE;
      end else begin
         fault_s = fault_r;
      end
   end

   // State registers.
   always_ff @(posedge CLOCK or negedge CLEAR_N) begin
      if (!CLEAR_N) begin
         cyc_r        <= 16'd0;
         main_prev_r  <= LAMP_RED;
         cntry_prev_r <= LAMP_RED;
         primed_r     <= 1'b0;
         main_yel_r   <= {YW{1'b0}};
         cntry_yel_r  <= {YW{1'b0}};
         clr_r        <= {CW{1'b0}};
         starve_r     <= {SW{1'b0}};
         fault_r      <= 1'b0;
         code_r       <= CODE_NONE;
         time_r       <= 16'd0;
      end else begin
         cyc_r        <= cyc_r + 16'd1;
         main_prev_r  <= MAIN_SIG;
         cntry_prev_r <= CNTRY_SIG;
         primed_r     <= 1'b1;
         main_yel_r   <= main_yel_s;
         cntry_yel_r  <= cntry_yel_s;
         clr_r        <= clr_s;
         starve_r     <= starve_s;
         fault_r      <= fault_s;
         code_r       <= code_s;
         time_r       <= time_s;
      end
   end

   assign FAULT      = fault_r;
   assign FORCE_RED  = fault_r;
   assign FAULT_CODE = code_r;
   assign FAULT_TIME = time_r;

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Bench for signal_conflict_monitor: directed scenarios plus random lamp walks
// checked against a history-based reference model.
module tb_signal_conflict_monitor;

   localparam int Y2R = 3;
   localparam int R2G = 2;
   localparam int MW  = 20;

   logic        clk;
   logic        clear_n;
   logic [1:0]  main_sig;
   logic [1:0]  cntry_sig;
   logic        car;
   logic        ack;
   logic        fault;
   logic [2:0]  fault_code;
   logic [15:0] fault_time;
   logic        force_red;

   int errors = 0;
   int checks = 0;

   int mh[$];
   int ch[$];
   int carh[$];
   int exp_fault;
   int exp_code;
   int exp_time;
   int cyc_m;

   signal_conflict_monitor #(.Y2RDELAY(Y2R), .R2GDELAY(R2G), .MAX_WAIT(MW)) dut (
      .CLOCK(clk), .CLEAR_N(clear_n), .MAIN_SIG(main_sig), .CNTRY_SIG(cntry_sig),
      .CAR_ON_CNTRY_RD(car), .FAULT_ACK(ack), .FAULT(fault), .FAULT_CODE(fault_code),
      .FAULT_TIME(fault_time), .FORCE_RED(force_red)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int yel_run(input bit on_main);
      int n = 0;
      for (int i = mh.size() - 1; i >= 0; i--) begin
         if ((on_main ? mh[i] : ch[i]) == 1) n++;
         else break;
      end
      return n;
   endfunction

   function automatic int red_run();
      int n = 0;
      for (int i = mh.size() - 1; i >= 0; i--) begin
         if (mh[i] == 0 && ch[i] == 0) n++;
         else break;
      end
      return n;
   endfunction

   function automatic int starve_run(input int c, input int cr);
      int n;
      if (!(cr == 1 && c != 2)) return 0;
      n = 1;
      for (int i = ch.size() - 1; i >= 0 && n < MW; i--) begin
         if (carh[i] == 1 && ch[i] != 2) n++;
         else break;
      end
      return n;
   endfunction

   function automatic bit is_bad(input int p, input int c);
      return (p == 2 && c == 0) || (p == 1 && c == 2) || (p == 0 && c == 1);
   endfunction

   function automatic int model_detect(input int m, input int c, input int cr);
      int pm, pc;
      if (m == 3 || c == 3) return 1;
      if (m != 0 && c != 0) return 2;
      if (mh.size() > 0) begin
         pm = mh[mh.size() - 1];
         pc = ch[ch.size() - 1];
         if (is_bad(pm, m) || is_bad(pc, c)) return 3;
         if ((pm == 1 && m == 0 && yel_run(1'b1) < Y2R) ||
             (pc == 1 && c == 0 && yel_run(1'b0) < Y2R)) return 4;
         if (((pm == 0 && m == 2) || (pc == 0 && c == 2)) && red_run() < R2G) return 5;
      end
      if (starve_run(c, cr) >= MW) return 6;
      return 0;
   endfunction

   task automatic model_clear();
      mh.delete(); ch.delete(); carh.delete();
      exp_fault = 0; exp_code = 0; exp_time = 0; cyc_m = 0;
   endtask

   task automatic drive_edge(input int m, input int c, input int cr, input int a);
      int d;
      main_sig = 2'(m); cntry_sig = 2'(c); car = cr[0]; ack = a[0];
      @(posedge clk);
      d = model_detect(m, c, cr);
      if (d != 0 && (exp_fault == 0 || a == 1)) begin
         exp_fault = 1; exp_code = d; exp_time = cyc_m;
      end else if (d == 0 && exp_fault == 1 && a == 1) begin
         exp_fault = 0; exp_code = 0;
      end
      mh.push_back(m); ch.push_back(c); carh.push_back(cr);
      if (mh.size() > 64) begin
         void'(mh.pop_front()); void'(ch.pop_front()); void'(carh.pop_front());
      end
      cyc_m = (cyc_m + 1) & 16'hFFFF;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clear_n = 1'b0;
      main_sig = 2'd0; cntry_sig = 2'd0; car = 1'b0; ack = 1'b0;
      model_clear();
      @(negedge clk);
      clear_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      clear_n = 1'b0;
      #1;
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %0d expected 0", fault); end
      checks++; if (fault_code !== 3'd0) begin errors++; $display("FAIL reset_code: got %0d expected 0", fault_code); end
      checks++; if (fault_time !== 16'd0) begin errors++; $display("FAIL reset_time: got %0d expected 0", fault_time); end
      main_sig = 2'd3; cntry_sig = 2'd2; car = 1'b1; ack = 1'b0;
      @(posedge clk); #1;
      checks++; if (force_red !== 1'b0) begin errors++; $display("FAIL reset_held_force: got %0d expected 0", force_red); end
      do_reset();
   endtask

   task automatic test_legal_cycle();
      do_reset();
      for (int i = 0; i < 10; i++) drive_edge(2, 0, 0, 0);
      for (int i = 0; i < 3; i++) drive_edge(1, 0, 0, 0);
      for (int i = 0; i < 2; i++) drive_edge(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) drive_edge(0, 2, 0, 0);
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL legal_fault: got %0d expected 0", fault); end
      checks++; if (fault_code !== 3'd0) begin errors++; $display("FAIL legal_code: got %0d expected 0", fault_code); end
   endtask

   task automatic test_conflict();
      do_reset();
      for (int i = 0; i < 40; i++) drive_edge(2, 0, 0, 0);
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL conflict_pre: got %0d expected 0", fault); end
      drive_edge(2, 2, 0, 0);
      checks++; if (fault !== 1'b1) begin errors++; $display("FAIL conflict_fault: got %0d expected 1", fault); end
      checks++; if (fault_code !== 3'd2) begin errors++; $display("FAIL conflict_code: got %0d expected 2", fault_code); end
      checks++; if (fault_time !== 16'd40) begin errors++; $display("FAIL conflict_time: got %0d expected 40", fault_time); end
      checks++; if (force_red !== 1'b1) begin errors++; $display("FAIL conflict_force: got %0d expected 1", force_red); end
   endtask

   task automatic test_short_yellow();
      do_reset();
      for (int i = 0; i < 3; i++) drive_edge(2, 0, 0, 0);
      for (int i = 0; i < 2; i++) drive_edge(1, 0, 0, 0);
      drive_edge(0, 0, 0, 0);
      checks++; if (fault_code !== 3'd4) begin errors++; $display("FAIL sy_code: got %0d expected 4", fault_code); end
      checks++; if (fault_time !== 16'd5) begin errors++; $display("FAIL sy_time: got %0d expected 5", fault_time); end
      drive_edge(0, 0, 0, 0);
      drive_edge(0, 0, 0, 0);
      drive_edge(0, 2, 0, 0);
      drive_edge(2, 2, 0, 0);
      checks++; if (fault_code !== 3'd4) begin errors++; $display("FAIL sy_sticky_code: got %0d expected 4", fault_code); end
      checks++; if (fault_time !== 16'd5) begin errors++; $display("FAIL sy_sticky_time: got %0d expected 5", fault_time); end
      for (int i = 0; i < 3; i++) drive_edge(1, 1, 0, 0);
      drive_edge(0, 0, 0, 1);
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL ack_fault: got %0d expected 0", fault); end
      checks++; if (fault_code !== 3'd0) begin errors++; $display("FAIL ack_code: got %0d expected 0", fault_code); end
      checks++; if (fault_time !== 16'd5) begin errors++; $display("FAIL ack_time: got %0d expected 5", fault_time); end
   endtask

   task automatic test_seq_illegal();
      do_reset();
      for (int i = 0; i < 3; i++) drive_edge(2, 0, 0, 0);
      drive_edge(0, 0, 0, 0);
      checks++; if (fault_code !== 3'd3) begin errors++; $display("FAIL seq_code: got %0d expected 3", fault_code); end
      checks++; if (fault_time !== 16'd3) begin errors++; $display("FAIL seq_time: got %0d expected 3", fault_time); end
      drive_edge(3, 0, 0, 0);
      checks++; if (fault_code !== 3'd3) begin errors++; $display("FAIL seq_sticky: got %0d expected 3", fault_code); end
      do_reset();
      drive_edge(0, 0, 0, 0);
      drive_edge(0, 0, 0, 0);
      drive_edge(3, 2, 0, 0);
      checks++; if (fault_code !== 3'd1) begin errors++; $display("FAIL illegal_code: got %0d expected 1", fault_code); end
      checks++; if (fault_time !== 16'd2) begin errors++; $display("FAIL illegal_time: got %0d expected 2", fault_time); end
   endtask

   task automatic test_starve();
      do_reset();
      for (int i = 0; i < 19; i++) drive_edge(2, 0, 1, 0);
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL starve_early: got %0d expected 0", fault); end
      drive_edge(2, 0, 1, 0);
      checks++; if (fault_code !== 3'd6) begin errors++; $display("FAIL starve_code: got %0d expected 6", fault_code); end
      checks++; if (fault_time !== 16'd19) begin errors++; $display("FAIL starve_time: got %0d expected 19", fault_time); end
      do_reset();
      for (int i = 0; i < 19; i++) drive_edge(2, 0, 1, 0);
      drive_edge(2, 0, 0, 0);
      for (int i = 0; i < 15; i++) drive_edge(2, 0, 1, 0);
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL starve_drop: got %0d expected 0", fault); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive_edge(2, 0, 0, 0);
      drive_edge(2, 2, 0, 0);
      drive_edge(3, 0, 0, 1);
      checks++; if (fault !== 1'b1) begin errors++; $display("FAIL b2b_fault: got %0d expected 1", fault); end
      checks++; if (fault_code !== 3'd1) begin errors++; $display("FAIL b2b_code: got %0d expected 1", fault_code); end
      checks++; if (fault_time !== 16'd2) begin errors++; $display("FAIL b2b_time: got %0d expected 2", fault_time); end
   endtask

   task automatic test_async_reset();
      do_reset();
      drive_edge(2, 0, 0, 0);
      drive_edge(2, 2, 0, 0);
      #2;
      clear_n = 1'b0;
      #1;
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL async_fault: got %0d expected 0", fault); end
      checks++; if (fault_code !== 3'd0) begin errors++; $display("FAIL async_code: got %0d expected 0", fault_code); end
      checks++; if (fault_time !== 16'd0) begin errors++; $display("FAIL async_time: got %0d expected 0", fault_time); end
      checks++; if (force_red !== 1'b0) begin errors++; $display("FAIL async_force: got %0d expected 0", force_red); end
      model_clear();
      @(negedge clk);
      clear_n = 1'b1;
      drive_edge(2, 0, 0, 0);
      drive_edge(2, 0, 0, 0);
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL post_reset_prime: got %0d expected 0", fault); end
   endtask

   task automatic test_random();
      int m, c, cr, a, r;
      do_reset();
      m = 2; c = 0; cr = 0;
      for (int i = 0; i < 1500; i++) begin
         r = $urandom_range(0, 31);
         if (r == 0) m = $urandom_range(0, 3);
         else if (r <= 3) m = (m == 2) ? 1 : (m == 1) ? 0 : (m == 0) ? 2 : 0;
         r = $urandom_range(0, 31);
         if (r == 0) c = $urandom_range(0, 3);
         else if (r <= 3) c = (c == 2) ? 1 : (c == 1) ? 0 : (c == 0) ? 2 : 0;
         if ($urandom_range(0, 15) == 0) cr = 1 - cr;
         a = ($urandom_range(0, 5) == 0) ? 1 : 0;
         drive_edge(m, c, cr, a);
         checks++; if (fault !== exp_fault[0]) begin errors++; $display("FAIL rand_fault@%0d: got %0d expected %0d", i, fault, exp_fault); end
         checks++; if (fault_code !== exp_code[2:0]) begin errors++; $display("FAIL rand_code@%0d: got %0d expected %0d", i, fault_code, exp_code); end
         checks++; if (fault_time !== exp_time[15:0]) begin errors++; $display("FAIL rand_time@%0d: got %0d expected %0d", i, fault_time, exp_time); end
         checks++; if (force_red !== exp_fault[0]) begin errors++; $display("FAIL rand_force@%0d: got %0d expected %0d", i, force_red, exp_fault); end
      end
   endtask

   initial begin
      clear_n = 1'b0; main_sig = 2'd0; cntry_sig = 2'd0; car = 1'b0; ack = 1'b0;
      model_clear();
      test_reset();
      test_legal_cycle();
      test_conflict();
      test_short_yellow();
      test_seq_illegal();
      test_starve();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
